fp32_add_arbiter: RTL

Round-robin scheduler that shares one combinational FP32 adder among NREQ requesters in the matrix-multiplier datapath. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one request at a time, registers the operands into the shared adder and captures the sum. It returns the sum on a common response channel tagged with the requester index.

---
 rtl/fp32_add_arbiter_if.sv | 34 +++
 rtl/fp32_add_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fp32_add_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : fp32_add_arbiter_if
//  Purpose  : Request, shared-adder and response bundle for fp32_add_arbiter.
//             slave  = arbiter view, master = requester/adder/consumer view.
//  Revision : 1.0  initial release
// ============================================================================
interface fp32_add_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [31:0]        add_a;
  logic [31:0]        add_b;
  logic [31:0]        add_sum;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_sum;

  modport slave (
    input  req_valid, req_a, req_b, add_sum, rsp_ready,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum
  );

  modport master (
    output req_valid, req_a, req_b, add_sum, rsp_ready,
    input  req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum
  );
endinterface
`default_nettype wire

// File: rtl/fp32_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fp32_add_arbiter
//  Purpose  : Round-robin sharing of one combinational FP32 adder among NREQ
//             requesters. Grant -> operand registers -> sum register ->
//             tagged response. FP32 values pass through untouched.
//  Config   : FP32_ARB_PERF_EN adds perf_ops / perf_stall counters.
//  Revision : 1.0  initial release
// ============================================================================
module fp32_add_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  fp32_add_arbiter_if.slave   bus
`ifdef FP32_ARB_PERF_EN
  ,
  output logic [31:0]         perf_ops,
  output logic [31:0]         perf_stall
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q;
  logic [31:0]    add_a_q, add_b_q;
  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [31:0]    rsp_sum_q;

  logic           found;
  logic [IDW-1:0] win_idx;
  logic           grant;

  logic [31:0]    a_arr [NREQ];
  logic [31:0]    b_arr [NREQ];

  // Slice the packed operand buses into per-requester words
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = bus.req_a[32*i +: 32];
    assign b_arr[i] = bus.req_b[32*i +: 32];
  end

  // Round-robin search: first valid requester at or above ptr, wrapping
  always_comb begin
    int idx;
    found   = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req_valid[idx[IDW-1:0]]) begin
        found   = 1'b1;
        win_idx = idx[IDW-1:0];
      end
    end
  end

  // A grant is only possible when the operand registers are free to load;
  // reset suppresses it so req_ready stays low while rst is held.
  assign grant = found && !rst &&
                 ((state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready));

  assign ptr_d = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = grant ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture on grant, sum capture in EXEC, response retire in RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      id_q        <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
    end else begin
      if (grant) begin
        add_a_q <= a_arr[win_idx];
        add_b_q <= b_arr[win_idx];
        id_q    <= win_idx;
        ptr_q   <= ptr_d;
      end
      if (state_q == EXEC) begin
        rsp_sum_q   <= bus.add_sum;
        rsp_id_q    <= id_q;
        rsp_valid_q <= 1'b1;
      end else if ((state_q == RESP) && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready = grant ? (NREQ'(1) << win_idx) : '0;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;

`ifdef FP32_ARB_PERF_EN
  logic [31:0] perf_ops_q, perf_stall_q;

  // Completed responses and backpressured response cycles, wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (rsp_valid_q && bus.rsp_ready)  perf_ops_q   <= perf_ops_q + 32'd1;
      if (rsp_valid_q && !bus.rsp_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule
`default_nettype wire
